// File: rtl/aes_pkg.sv
// Shared definitions for the AES128 AHB-Lite streaming front-end.
// Contents:
//   - the block width and the ECB/CTR mode constants
//   - word-offset constants for HADDR[6:2], plus the CTRL and EVENTS bit indices
//   - the sequencer FSM state encoding
//   - helpers to read or replace one 32-bit word of a 128-bit value (word0 = bits[127:96])
package aes_pkg;

  localparam int unsigned BLK_W = 128;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CTR = 1'b1;

  // Word offsets (HADDR[6:2]) of the scalar registers
  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h01;
  localparam logic [4:0] ADDR_EVENTS = 5'h02;

  // Upper three word-offset bits of the four-word banks; bits [1:0] select the word
  localparam logic [2:0] BANK_KEY  = 3'b001;
  localparam logic [2:0] BANK_DIN  = 3'b010;
  localparam logic [2:0] BANK_DOUT = 3'b011;
  localparam logic [2:0] BANK_CTR  = 3'b100;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_MODE   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_FLUSH  = 3;

  localparam int unsigned EV_DONE    = 0;
  localparam int unsigned EV_OVF     = 1;
  localparam int unsigned EV_UNF     = 2;
  localparam int unsigned EV_KEY_ERR = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } fsm_e;

  function automatic logic [31:0] word_of(input logic [BLK_W-1:0] v, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] set_word(input logic [BLK_W-1:0] v,
                                                input logic [1:0]       idx,
                                                input logic [31:0]      w);
    logic [BLK_W-1:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with a first-word-fall-through head.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data; dropped while full
//   pop            read request; ignored while empty
//   flush          empties the FIFO, takes priority over push and pop
//   rdata          current head (valid when !empty)
//   full, empty    status flags
//   count          number of stored entries, 0..DEPTH
module aes_blk_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = cnt_q;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (do_push != do_pop) cnt_q <= do_push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/aes_ahb_stream.sv
// AHB-Lite slave front-end that streams queued blocks through one AES128 core.
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HSEL..HWDATA            AHB-Lite slave inputs (zero wait state)
//   HRDATA                  read data, driven in the data phase
//   HREADYOUT, HRESP        constant 1 / OKAY
//   core_start              one-cycle start pulse to the core
//   core_key, core_block    key and block presented to the core
//   core_done, core_result  core result strobe and data
//   irq                     registered level interrupt
module aes_ahb_stream #(
  parameter int unsigned BLK_W      = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          CTR_EN     = 1'b1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic             core_start,
  output logic [BLK_W-1:0] core_key,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_result,
  output logic             irq
);

  import aes_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Bus address/data phase
  logic       accept;
  logic [4:0] addr_q;
  logic       wr_q, rd_q;
  logic [1:0] widx;
  logic       wr_ctrl, wr_events, wr_key, wr_din, wr_ctr, flush, din_push, rd_pop;
  logic       unused_ok;

  // Control/status state
  fsm_e             state_q, state_d;
  logic             en_q, mode_q, irq_en_q, irq_q, discard_q, cur_ctr_q;
  logic [3:0]       events_q, events_d, ev_set;
  logic [BLK_W-1:0] key_q, din_q, ctr_q, hold_q, blk_q, res_q, wb_result;
  logic             issue_ctr, in_pop, out_push, done_set;

  // FIFO interface
  logic [BLK_W-1:0] in_head, out_head;
  logic             in_full, in_empty, out_full, out_empty;
  logic [CW-1:0]    in_cnt, out_cnt;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign unused_ok = ^{HADDR[31:7], HADDR[1:0], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      if (accept) addr_q <= HADDR[6:2];
      wr_q <= accept & HWRITE;
      rd_q <= accept & ~HWRITE;
    end
  end

  assign widx      = addr_q[1:0];
  assign wr_ctrl   = wr_q && (addr_q == ADDR_CTRL);
  assign wr_events = wr_q && (addr_q == ADDR_EVENTS);
  assign wr_key    = wr_q && (addr_q[4:2] == BANK_KEY);
  assign wr_din    = wr_q && (addr_q[4:2] == BANK_DIN);
  assign wr_ctr    = wr_q && (addr_q[4:2] == BANK_CTR);
  assign flush     = wr_ctrl && HWDATA[CTRL_FLUSH];
  assign din_push  = wr_din && (widx == 2'd3);
  assign rd_pop    = rd_q && (addr_q == {BANK_DOUT, 2'd3});

  aes_blk_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (din_push),
    .wdata ({din_q[BLK_W-1:32], HWDATA}),
    .pop   (in_pop),
    .flush (flush),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_cnt)
  );

  aes_blk_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (out_push),
    .wdata (wb_result),
    .pop   (rd_pop & ~out_empty),
    .flush (flush),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_cnt)
  );

  assign issue_ctr  = CTR_EN && (mode_q == MODE_CTR);
  assign wb_result  = cur_ctr_q ? (res_q ^ hold_q) : res_q;
  assign core_key   = key_q;
  // The issue value is live only during ISSUE; afterwards the latched copy stays on the bus
  assign core_block = (state_q == StIssue) ? (issue_ctr ? ctr_q : in_head) : blk_q;
  assign irq        = irq_q;

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_q && !in_empty && !out_full) state_d = StIssue;
      end
      StIssue: begin
        core_start = 1'b1;
        in_pop     = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        // A block flushed while in flight is still waited for, then dropped
        if (core_done) state_d = (discard_q || flush) ? StIdle : StWb;
      end
      StWb: begin
        out_push = ~flush;
        done_set = ~flush;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ev_set              = '0;
    ev_set[EV_DONE]     = done_set;
    ev_set[EV_OVF]      = din_push & in_full;
    ev_set[EV_UNF]      = rd_pop & out_empty;
    ev_set[EV_KEY_ERR]  = (wr_key | wr_ctr) & (state_q != StIdle);
    // Set wins over a same-cycle W1C
    events_d = events_q;
    if (wr_events) events_d = events_d & ~HWDATA[3:0];
    events_d = events_d | ev_set;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      mode_q    <= MODE_ECB;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      discard_q <= 1'b0;
      cur_ctr_q <= 1'b0;
      events_q  <= '0;
      key_q     <= '0;
      din_q     <= '0;
      ctr_q     <= '0;
      hold_q    <= '0;
      blk_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q  <= state_d;
      events_q <= events_d;
      irq_q    <= irq_en_q & (|events_q);
      if (wr_ctrl) begin
        en_q     <= HWDATA[CTRL_EN];
        mode_q   <= CTR_EN ? HWDATA[CTRL_MODE] : MODE_ECB;
        irq_en_q <= HWDATA[CTRL_IRQ_EN];
      end
      if (wr_key && state_q == StIdle) key_q <= set_word(key_q, widx, HWDATA);
      if (wr_din) din_q <= set_word(din_q, widx, HWDATA);
      if (state_q == StIssue) begin
        hold_q    <= in_head;
        blk_q     <= issue_ctr ? ctr_q : in_head;
        cur_ctr_q <= issue_ctr;
        if (issue_ctr) ctr_q <= ctr_q + BLK_W'(1);
      end else if (CTR_EN && wr_ctr && state_q == StIdle) begin
        ctr_q <= set_word(ctr_q, widx, HWDATA);
      end
      if (state_q == StWait && core_done) res_q <= core_result;
      if (state_q == StIdle) discard_q <= 1'b0;
      else if (flush)        discard_q <= 1'b1;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      if (addr_q == ADDR_CTRL) begin
        HRDATA[CTRL_EN]     = en_q;
        HRDATA[CTRL_MODE]   = mode_q;
        HRDATA[CTRL_IRQ_EN] = irq_en_q;
      end else if (addr_q == ADDR_STATUS) begin
        HRDATA[0]    = (state_q != StIdle);
        HRDATA[1]    = in_full;
        HRDATA[2]    = out_empty;
        HRDATA[7:4]  = 4'(in_cnt);
        HRDATA[11:8] = 4'(out_cnt);
      end else if (addr_q == ADDR_EVENTS) begin
        HRDATA[3:0] = events_q;
      end else begin
        case (addr_q[4:2])
          BANK_KEY:  HRDATA = word_of(key_q, widx);
          BANK_DIN:  HRDATA = word_of(din_q, widx);
          BANK_DOUT: HRDATA = out_empty ? 32'd0 : word_of(out_head, widx);
          BANK_CTR:  HRDATA = word_of(ctr_q, widx);
          default:   HRDATA = '0;
        endcase
      end
    end
  end

endmodule
